// File: rtl/weight_ram_arbiter.sv
// rtl/weight_ram_arbiter.sv - round-robin read/write arbiter for a single-port weight RAM
// Issues at most one registered RAM op per cycle and returns read data with fixed 3-cycle latency.
module weight_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  // last_wr = 1 means the writer won the most recent accept, so a tie goes to the reader
  logic last_wr;
  logic rd_p1;
  logic rd_p2;

  always_comb begin
    rd_gnt = rst_n & rd_req & (~wr_req | last_wr);
    wr_gnt = rst_n & wr_req & (~rd_req | ~last_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr   <= 1'b1;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= rd_gnt | wr_gnt;
      ram_we <= wr_gnt;
      if (rd_gnt | wr_gnt) begin
        last_wr  <= wr_gnt;
        ram_addr <= wr_gnt ? wr_addr : rd_addr;
      end
      if (wr_gnt) begin
        ram_wdata <= wr_data;
      end
    end
  end

  // rd_p1: read op on the RAM bus; rd_p2: ram_rdata carries that read's word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p1    <= 1'b0;
      rd_p2    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_p1    <= rd_gnt;
      rd_p2    <= rd_p1;
      rd_valid <= rd_p2;
      if (rd_p2) begin
        rd_data <= ram_rdata;
      end
    end
  end

  assign busy = ram_en | rd_p1 | rd_p2;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// tb/tb_weight_ram_arbiter.sv - randomized bench for weight_ram_arbiter against a shadow-memory model
// The bench owns the single-port RAM; expectations come from a per-accept shadow memory and return queue.
module tb_weight_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_gnt;
  logic        ram_en;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        busy;

  weight_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // single-port RAM, registered read, read-before-write
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] shadow [32];
  ret_t        rq[$];
  logic        lw_wr;
  logic        e_en, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_wdata;
  logic [31:0] last_rd;
  int          rd_grants, wr_grants;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    lw_wr   = 1'b1;
    e_en    = 1'b0;
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    last_rd = '0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    @(negedge clk);
    check("rst_rd_gnt", rd_gnt, 1'b0);
    check("rst_wr_gnt", wr_gnt, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 5'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rd_req = 1'b0;
    wr_req = 1'b0;
    cyc++;
  endtask

  task automatic step(input logic rr, input logic [4:0] ra, input logic wr,
                      input logic [4:0] wa, input logic [31:0] wd);
    logic eg_rd, eg_wr, exp_busy;
    rd_req  = rr;
    rd_addr = ra;
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    @(negedge clk);
    eg_rd = rr & (!wr | lw_wr);
    eg_wr = wr & (!rr | !lw_wr);
    check("rd_gnt", rd_gnt, eg_rd);
    check("wr_gnt", wr_gnt, eg_wr);
    check("ram_en", ram_en, e_en);
    check("ram_we", ram_we, e_we);
    check("ram_addr", ram_addr, e_addr);
    check("ram_wdata", ram_wdata, e_wdata);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rd_valid", rd_valid, 1'b1);
      check("rd_data", rd_data, rq[0].data);
      last_rd = rq[0].data;
      void'(rq.pop_front());
    end else begin
      check("rd_valid", rd_valid, 1'b0);
      check("rd_data_hold", rd_data, last_rd);
    end
    exp_busy = e_en;
    foreach (rq[i]) if (rq[i].due == cyc + 1) exp_busy = 1'b1;
    check("busy", busy, exp_busy);
    // model state for the next cycle
    e_en = eg_rd | eg_wr;
    e_we = eg_wr;
    if (eg_rd) begin
      e_addr = ra;
      rq.push_back('{due: cyc + 3, data: shadow[ra]});
      lw_wr = 1'b0;
      rd_grants++;
    end
    if (eg_wr) begin
      e_addr     = wa;
      e_wdata    = wd;
      shadow[wa] = wd;
      lw_wr      = 1'b1;
      wr_grants++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #2;
    rd_grants = 0;
    wr_grants = 0;
    do_reset();
    // preload every address through the write port
    for (int a = 0; a < 32; a++)
      step(1'b0, 5'd0, 1'b1, 5'(a), (a == 3) ? 32'h0000_00AA : $urandom);
    idle(3);
    do_reset();

    // single read of address 3
    step(1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
    idle(5);

    // write then read-after-write on the next cycle
    step(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234_5678);
    step(1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    idle(4);
    check("raw_data", last_rd, 32'h1234_5678);

    // read then write to the same address returns old data
    step(1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
    idle(4);

    // sustained contention alternates
    do_reset();
    rd_grants = 0;
    wr_grants = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 5'(i), 1'b1, 5'(i + 10), $urandom);
    check("alt_rd_count", rd_grants, 3);
    check("alt_wr_count", wr_grants, 3);
    idle(4);

    // back-to-back reads
    for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 1'b0, 5'd0, 32'd0);
    idle(5);

    // reset one cycle after a read accept drops the return
    step(1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    do_reset();
    idle(5);

    // requests held a single cycle then dropped
    step(1'b1, 5'd2, 1'b1, 5'd4, 32'hA5A5_0001);
    idle(5);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    idle(5);
    check("queue_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
